uart_apb_bridge_master: RTL and testbench
=========================================

Name: uart_apb_bridge_master

Overview:
- Debug bridge that lets a host PC, over a UART link, act as an APB initiator on the peripheral bus.
- It receives 8N1 command frames, turns each one into a single 32-bit APB read or write, and sends a status byte or the read data back over UART.
- It is the counterpart of the APB responders (GPIO, PWM, UART, I2C, SPI, CONFREG, HPET): it drives the bus rather than answering it.
- It connects to a spare APB arbiter port and to the board-level RsRx/RsTx pins.

Parameters:
- CLK_DIV, 434: CLK50M cycles per UART bit (115200 baud); minimum 8.
- APB_TIMEOUT, 1024: maximum ACCESS-phase cycles waiting for m_pready before abort.
- FRAME_TIMEOUT, 5000000: idle CLK50M cycles allowed between bytes of one frame (0.1 s).

Ports:
- CLK50M  input  1  system clock.
- RSTN  input  1  reset.
- uart_rx  input  1  serial in from host; asynchronous, idle high.
- uart_tx  output  1  serial out to host, idle high.
- m_psel  output  1  APB select.
- m_penable  output  1  APB enable.
- m_pwrite  output  1  1 = write.
- m_paddr  output  32  APB address.
- m_pwdata  output  32  APB write data.
- m_prdata  input  32  APB read data.
- m_pready  input  1  APB ready from responder.
- busy  output  1  high from first command byte until the last response stop bit completes.

Behaviour:
- Reset: reset RSTN, asynchronous, active-low; clock CLK50M. On reset: uart_tx=1; m_psel=0; m_penable=0; m_pwrite=0; m_paddr=0; m_pwdata=0; busy=0; all FSMs go to IDLE; all counters clear.
- Reset mid-transfer: the APB access is dropped immediately (psel/penable go low) and any partial UART byte is discarded.
- RX path:
  - uart_rx passes through a 2-flop synchronizer.
  - A falling edge in RX_IDLE starts a bit counter. The line is re-sampled at CLK_DIV/2; if it is high, the edge is a glitch and RX returns to idle.
  - The 8 data bits are sampled LSB first, each CLK_DIV cycles after the previous sample.
  - The stop bit is sampled at its midpoint. If it is 0, this is a framing error: the byte is dropped and the frame parser resets to CMD.
  - A valid byte raises an internal 1-cycle rx_valid pulse at the stop-bit sample.
- Frame parser FSM, states CMD, ADDR, DATA, EXEC, RESP:
  - In CMD:
    - 0x57 'W' selects write; expect 4 address bytes then 4 data bytes.
    - 0x52 'R' selects read; expect 4 address bytes.
    - Any other byte: queue a 0x3F '?' response and stay in CMD.
  - Address and data bytes arrive MSB first; each byte shifts into the register's LSB.
  - While in ADDR or DATA, if the gap between bytes reaches FRAME_TIMEOUT cycles, the partial frame is discarded silently, the state returns to CMD and busy drops.
  - Bytes received during EXEC or RESP are discarded. There is no RX buffering.
- APB master (within EXEC):
  - SETUP starts on the cycle after the final rx_valid: m_psel=1, m_penable=0, and m_paddr, m_pwrite and m_pwdata are valid.
  - The next cycle enters ACCESS: m_penable=1, held until m_pready=1.
  - On the m_pready cycle, m_prdata is captured for reads. On the following cycle m_psel and m_penable return to 0.
  - m_paddr, m_pwdata and m_pwrite hold their values until the next SETUP.
  - If m_pready stays low for APB_TIMEOUT ACCESS cycles, the access is aborted with psel and penable deasserted next cycle, and the response is 0x54 'T'.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: 4 bytes of read data, MSB first.
  - Timeout: 'T' only, with no data bytes.
  - RESP starts TX on the cycle after the APB access completes.
- TX path:
  - Each byte is sent as start bit (0), 8 data bits LSB first, stop bit (1), each bit lasting CLK_DIV cycles.
  - Consecutive response bytes are sent back-to-back with no extra idle time.
  - After the last stop bit, the parser returns to CMD and busy drops.
- A minimum complete APB transfer takes exactly 2 psel cycles. Only one access is ever outstanding.

Test Plan:
- Write, zero wait states: send 57 40 00 00 10 DE AD BE EF with pready tied 1 -> one SETUP then one ACCESS cycle with paddr=0x40000010, pwdata=0xDEADBEEF, pwrite=1; uart_tx then sends 0x4B; busy drops after its stop bit.
- Read with wait states: send 52 40 00 00 04; responder holds pready=0 for 3 ACCESS cycles, then returns prdata=0x12345678 -> penable is high for 4 cycles; TX sends 12 34 56 78 in that order.
- APB timeout: read with pready held at 0 -> after 1024 ACCESS cycles psel and penable drop; TX sends 0x54 only.
- Bad command and framing error:
  - Send 0xA5 -> TX sends 0x3F and there is no APB activity.
  - Send a byte with stop bit 0 -> no response, parser stays in CMD.
- Frame timeout and glitch: send 57 40 00, wait 5000000 cycles, then send 52 40 00 00 00 -> the first frame is discarded; the read to 0x40000000 executes normally. A 100-cycle low glitch on uart_rx -> no byte is received.
- Async reset during ACCESS (pready=0): assert RSTN low -> psel, penable and busy go low and uart_tx goes high immediately; after release, a fresh write frame succeeds.

Source files
------------

// File: rtl/uart_apb_bridge_master.sv
`default_nettype none
// ============================================================================
// Module   : uart_apb_bridge_master
// Purpose  : UART (8N1) command frames to single 32-bit APB accesses, with a
//            status byte or read data returned over UART.
// Revision : 1.0 - initial release
// ============================================================================
module uart_apb_bridge_master #(
  parameter int CLK_DIV       = 434,
  parameter int APB_TIMEOUT   = 1024,
  parameter int FRAME_TIMEOUT = 5000000
) (
  input  logic        CLK50M,
  input  logic        RSTN,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        m_psel,
  output logic        m_penable,
  output logic        m_pwrite,
  output logic [31:0] m_paddr,
  output logic [31:0] m_pwdata,
  input  logic [31:0] m_prdata,
  input  logic        m_pready,
  output logic        busy
);
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int AW = $clog2(APB_TIMEOUT + 1);
  localparam int FW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLK_DIV / 2 - 1);
  localparam logic [AW-1:0] c_apb_last  = AW'(APB_TIMEOUT - 1);
  localparam logic [FW-1:0] c_gap_last  = FW'(FRAME_TIMEOUT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {CMD, ADDR, DATA, EXEC, RESP} p_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t r_rx_st, w_rx_nxt;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_byte;
  logic w_rx_fall, w_rx_tick, w_rx_valid, w_rx_ferr;

  p_state_t r_st, w_nxt;
  logic r_is_wr;
  logic [1:0] r_bcnt;
  logic [31:0] r_addr_sh, r_data_sh;
  logic [FW-1:0] r_gap;
  logic r_psel, r_penable, r_pwrite;
  logic [31:0] r_paddr, r_pwdata;
  logic [AW-1:0] r_apb_cnt;
  logic [31:0] r_resp;
  logic [2:0] r_resp_left;
  logic w_is_cmd, w_gap_to, w_last_byte, w_apb_ok, w_apb_to, w_apb_done;

  tx_state_t r_tx_st, w_tx_nxt;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0] r_tx_bit;
  logic [8:0] r_tx_sh;
  logic r_tx_out;
  logic w_tx_end, w_tx_last, w_tx_ready, w_tx_load;

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) {r_rx_meta, r_rx_sync, r_rx_prev} <= 3'b111;
    else       {r_rx_meta, r_rx_sync, r_rx_prev} <= {uart_rx, r_rx_meta, r_rx_sync};
  end
  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // Start bit is checked at half a bit time; later ticks land on bit centres.
  always_comb begin
    w_rx_nxt   = r_rx_st;
    w_rx_valid = 1'b0;
    w_rx_ferr  = 1'b0;
    w_rx_tick  = (r_rx_cnt == ((r_rx_st == RX_START) ? c_half_last : c_bit_last));
    case (r_rx_st)
      RX_IDLE:  if (w_rx_fall) w_rx_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_nxt   = RX_IDLE;
          w_rx_valid = r_rx_sync;
          w_rx_ferr  = ~r_rx_sync;
        end
      end
      default:  w_rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      r_rx_st   <= RX_IDLE;
      r_rx_cnt  <= '0;
      r_rx_bit  <= '0;
      r_rx_byte <= '0;
    end else begin
      r_rx_st <= w_rx_nxt;
      if (r_rx_st == RX_IDLE || w_rx_tick) r_rx_cnt <= '0;
      else                                 r_rx_cnt <= r_rx_cnt + 1'b1;
      if (r_rx_st == RX_DATA && w_rx_tick) begin
        r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
        r_rx_bit  <= r_rx_bit + 1'b1;
      end
    end
  end

  assign w_is_cmd    = (r_rx_byte == 8'h57) || (r_rx_byte == 8'h52);
  assign w_gap_to    = (r_st == ADDR || r_st == DATA) && !w_rx_valid && (r_gap == c_gap_last);
  assign w_last_byte = w_rx_valid && (r_bcnt == 2'd3) &&
                       ((r_st == ADDR && !r_is_wr) || r_st == DATA);
  assign w_apb_ok    = (r_st == EXEC) && r_penable && m_pready;
  assign w_apb_to    = (r_st == EXEC) && r_penable && !m_pready && (r_apb_cnt == c_apb_last);
  assign w_apb_done  = w_apb_ok | w_apb_to;

  always_comb begin
    w_nxt = r_st;
    case (r_st)
      CMD:  if (w_rx_valid && w_is_cmd) w_nxt = ADDR;
      ADDR: begin
        if (w_gap_to || w_rx_ferr)                w_nxt = CMD;
        else if (w_last_byte)                     w_nxt = EXEC;
        else if (w_rx_valid && r_bcnt == 2'd3)    w_nxt = DATA;
      end
      DATA: begin
        if (w_gap_to || w_rx_ferr) w_nxt = CMD;
        else if (w_last_byte)      w_nxt = EXEC;
      end
      EXEC: if (w_apb_done) w_nxt = RESP;
      RESP: if (r_resp_left == 3'd0 && r_tx_st == TX_IDLE) w_nxt = CMD;
      default: w_nxt = CMD;
    endcase
  end

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) r_st <= CMD;
    else       r_st <= w_nxt;
  end

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      r_is_wr   <= 1'b0;
      r_bcnt    <= '0;
      r_gap     <= '0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_apb_cnt <= '0;
    end else begin
      if (r_st == CMD) begin
        r_bcnt <= '0;
        r_gap  <= '0;
        if (w_rx_valid) r_is_wr <= (r_rx_byte == 8'h57);
      end else if (r_st == ADDR || r_st == DATA) begin
        if (w_rx_valid) begin
          r_bcnt <= r_bcnt + 1'b1;
          r_gap  <= '0;
          if (r_st == ADDR) r_addr_sh <= {r_addr_sh[23:0], r_rx_byte};
          else              r_data_sh <= {r_data_sh[23:0], r_rx_byte};
        end else begin
          r_gap <= r_gap + 1'b1;
        end
      end
      // SETUP phase launches straight from the final frame byte.
      if (w_last_byte) begin
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_pwrite  <= r_is_wr;
        r_apb_cnt <= '0;
        r_paddr   <= (r_st == ADDR) ? {r_addr_sh[23:0], r_rx_byte} : r_addr_sh;
        if (r_st == DATA) r_pwdata <= {r_data_sh[23:0], r_rx_byte};
      end else if (r_st == EXEC) begin
        if (!r_penable) begin
          r_penable <= 1'b1;
        end else if (w_apb_done) begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end else begin
          r_apb_cnt <= r_apb_cnt + 1'b1;
        end
      end
    end
  end

  // Response bytes leave MSB first from the top of r_resp.
  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      r_resp      <= '0;
      r_resp_left <= '0;
    end else if (r_st == CMD && w_rx_valid && !w_is_cmd) begin
      r_resp      <= {8'h3F, 24'h0};
      r_resp_left <= 3'd1;
    end else if (w_apb_ok) begin
      r_resp      <= r_pwrite ? {8'h4B, 24'h0} : m_prdata;
      r_resp_left <= r_pwrite ? 3'd1 : 3'd4;
    end else if (w_apb_to) begin
      r_resp      <= {8'h54, 24'h0};
      r_resp_left <= 3'd1;
    end else if (w_tx_load) begin
      r_resp      <= {r_resp[23:0], 8'h00};
      r_resp_left <= r_resp_left - 1'b1;
    end
  end

  assign w_tx_end   = (r_tx_st == TX_SEND) && (r_tx_cnt == c_bit_last);
  assign w_tx_last  = w_tx_end && (r_tx_bit == 4'd9);
  assign w_tx_ready = (r_tx_st == TX_IDLE) || w_tx_last;
  assign w_tx_load  = (r_resp_left != 3'd0) && w_tx_ready;

  always_comb begin
    w_tx_nxt = r_tx_st;
    if (w_tx_load)      w_tx_nxt = TX_SEND;
    else if (w_tx_last) w_tx_nxt = TX_IDLE;
  end

  always_ff @(posedge CLK50M or negedge RSTN) begin
    if (!RSTN) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '1;
      r_tx_out <= 1'b1;
    end else begin
      r_tx_st <= w_tx_nxt;
      if (w_tx_load) begin
        r_tx_out <= 1'b0;
        r_tx_sh  <= {1'b1, r_resp[31:24]};
        r_tx_cnt <= '0;
        r_tx_bit <= '0;
      end else if (r_tx_st == TX_SEND) begin
        if (w_tx_end) begin
          r_tx_cnt <= '0;
          r_tx_bit <= r_tx_bit + 1'b1;
          r_tx_out <= r_tx_sh[0];
          r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
        end else begin
          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
      end
    end
  end

  assign uart_tx   = r_tx_out;
  assign m_psel    = r_psel;
  assign m_penable = r_penable;
  assign m_pwrite  = r_pwrite;
  assign m_paddr   = r_paddr;
  assign m_pwdata  = r_pwdata;
  assign busy      = (r_st != CMD) || (r_resp_left != 3'd0) || (r_tx_st != TX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_apb_bridge_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_apb_bridge_master
// Purpose  : Self-checking bench for the UART-to-APB debug bridge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_apb_bridge_master;
  localparam int CLK_DIV       = 32;
  localparam int APB_TIMEOUT   = 1024;
  localparam int FRAME_TIMEOUT = 3000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, m_psel, m_penable, m_pwrite, m_pready, busy;
  logic [31:0] m_paddr, m_pwdata, m_prdata;

  always #10 clk = ~clk;

  uart_apb_bridge_master #(
    .CLK_DIV(CLK_DIV), .APB_TIMEOUT(APB_TIMEOUT), .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) dut (
    .CLK50M(clk), .RSTN(rstn), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
    .m_pready(m_pready), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  time tx_start_q[$];
  int tx_bytes = 0;

  // Responder: ready after `waits` ACCESS cycles; negative means never ready.
  int waits = 0;
  int acc = 0;
  logic [31:0] rdata = '0;
  assign m_prdata = rdata;
  assign m_pready = m_psel && m_penable && (waits >= 0) && (acc == waits);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) acc <= 0;
    else if (m_psel && m_penable) acc <= acc + 1;
    else acc <= 0;
  end

  int psel_cyc = 0, pen_cyc = 0, setups = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic cap_write = 1'b0;
  always @(negedge clk) begin
    if (m_psel) begin
      psel_cyc <= psel_cyc + 1;
      if (m_penable) pen_cyc <= pen_cyc + 1;
      else begin
        setups    <= setups + 1;
        cap_addr  <= m_paddr;
        cap_wdata <= m_pwdata;
        cap_write <= m_pwrite;
      end
    end
  end

  // UART receiver on uart_tx; each decoded byte is checked against the scoreboard.
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    logic s0, sb;
    forever begin
      @(negedge uart_tx);
      tx_start_q.push_back($time);
      repeat (CLK_DIV / 2) @(posedge clk);
      #1 s0 = uart_tx;
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(posedge clk);
        #1 b[i] = uart_tx;
      end
      repeat (CLK_DIV) @(posedge clk);
      #1 sb = uart_tx;
      tx_bytes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %02h, required no byte", b);
      end else begin
        e = exp_q.pop_front();
        if (b !== e || s0 !== 1'b0 || sb !== 1'b1) begin
          bad++;
          $display("FAIL tx_byte: got %02h start=%b stop=%b, required %02h start=0 stop=1",
                   b, s0, sb, e);
        end
      end
    end
  end

  int b_psel, b_pen, b_setup, b_tx;
  task automatic mark();
    b_psel = psel_cyc; b_pen = pen_cyc; b_setup = setups; b_tx = tx_bytes;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CLK_DIV) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [71:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8], 1'b1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 20000) begin
      bad++;
      $display("FAIL %s_idle: busy=%b pending=%0d, required busy=0 pending=0",
               name, busy, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rst_tx: got %b, required 1", uart_tx); end
    total++; if (m_psel !== 1'b0) begin bad++; $display("FAIL rst_psel: got %b, required 0", m_psel); end
    total++; if (m_penable !== 1'b0) begin bad++; $display("FAIL rst_penable: got %b, required 0", m_penable); end
    total++; if (m_pwrite !== 1'b0) begin bad++; $display("FAIL rst_pwrite: got %b, required 0", m_pwrite); end
    total++; if (m_paddr !== 32'h0) begin bad++; $display("FAIL rst_paddr: got %08h, required 0", m_paddr); end
    total++; if (m_pwdata !== 32'h0) begin bad++; $display("FAIL rst_pwdata: got %08h, required 0", m_pwdata); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    mark();
    waits = 0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy: got %b, required 1", busy); end
    send_frame(72'h40000010_DEADBEEF, 8);
    wait_done("wr");
    total++; if (setups - b_setup !== 1) begin bad++; $display("FAIL wr_setups: got %0d, required 1", setups - b_setup); end
    total++; if (psel_cyc - b_psel !== 2) begin bad++; $display("FAIL wr_psel_cycles: got %0d, required 2", psel_cyc - b_psel); end
    total++; if (pen_cyc - b_pen !== 1) begin bad++; $display("FAIL wr_penable_cycles: got %0d, required 1", pen_cyc - b_pen); end
    total++; if (cap_addr !== 32'h40000010) begin bad++; $display("FAIL wr_paddr: got %08h, required 40000010", cap_addr); end
    total++; if (cap_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_pwdata: got %08h, required deadbeef", cap_wdata); end
    total++; if (cap_write !== 1'b1) begin bad++; $display("FAIL wr_pwrite: got %b, required 1", cap_write); end
    total++; if (tx_bytes - b_tx !== 1) begin bad++; $display("FAIL wr_tx_count: got %0d, required 1", tx_bytes - b_tx); end
  endtask

  task automatic test_read_wait();
    int base;
    mark();
    base = tx_start_q.size();
    waits = 3;
    rdata = 32'h12345678;
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_frame(72'h52_40000004, 5);
    wait_done("rd");
    total++; if (pen_cyc - b_pen !== 4) begin bad++; $display("FAIL rd_penable_cycles: got %0d, required 4", pen_cyc - b_pen); end
    total++; if (psel_cyc - b_psel !== 5) begin bad++; $display("FAIL rd_psel_cycles: got %0d, required 5", psel_cyc - b_psel); end
    total++; if (cap_addr !== 32'h40000004) begin bad++; $display("FAIL rd_paddr: got %08h, required 40000004", cap_addr); end
    total++; if (cap_write !== 1'b0) begin bad++; $display("FAIL rd_pwrite: got %b, required 0", cap_write); end
    total++;
    if (tx_start_q.size() < base + 4) begin
      bad++; $display("FAIL rd_tx_spacing: got %0d bytes, required 4", tx_start_q.size() - base);
    end else if (tx_start_q[base+3] - tx_start_q[base] !== time'(30 * CLK_DIV * 20)) begin
      bad++; $display("FAIL rd_tx_spacing: got %0t, required %0t",
                      tx_start_q[base+3] - tx_start_q[base], time'(30 * CLK_DIV * 20));
    end
  endtask

  task automatic test_timeout();
    mark();
    waits = -1;
    exp_q.push_back(8'h54);
    send_frame(72'h52_40000008, 5);
    wait_done("to");
    total++; if (pen_cyc - b_pen !== APB_TIMEOUT) begin bad++; $display("FAIL to_penable_cycles: got %0d, required %0d", pen_cyc - b_pen, APB_TIMEOUT); end
    total++; if (psel_cyc - b_psel !== APB_TIMEOUT + 1) begin bad++; $display("FAIL to_psel_cycles: got %0d, required %0d", psel_cyc - b_psel, APB_TIMEOUT + 1); end
    total++; if (tx_bytes - b_tx !== 1) begin bad++; $display("FAIL to_tx_count: got %0d, required 1", tx_bytes - b_tx); end
    waits = 0;
  endtask

  task automatic test_bad_cmd();
    mark();
    exp_q.push_back(8'h3F);
    send_byte(8'hA5, 1'b1);
    wait_done("badcmd");
    total++; if (setups - b_setup !== 0) begin bad++; $display("FAIL badcmd_apb: got %0d setups, required 0", setups - b_setup); end
    total++; if (tx_bytes - b_tx !== 1) begin bad++; $display("FAIL badcmd_tx_count: got %0d, required 1", tx_bytes - b_tx); end
  endtask

  task automatic test_framing();
    mark();
    send_byte(8'h57, 1'b0);
    repeat (2 * CLK_DIV) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy: got %b, required 0", busy); end
    total++; if (tx_bytes - b_tx !== 0) begin bad++; $display("FAIL ferr_tx_count: got %0d, required 0", tx_bytes - b_tx); end
    rdata = 32'hCAFEF00D;
    exp_q.push_back(8'hCA); exp_q.push_back(8'hFE);
    exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
    send_frame(72'h52_4000000C, 5);
    wait_done("ferr_rd");
    total++; if (cap_addr !== 32'h4000000C) begin bad++; $display("FAIL ferr_paddr: got %08h, required 4000000c", cap_addr); end
    total++; if (setups - b_setup !== 1) begin bad++; $display("FAIL ferr_setups: got %0d, required 1", setups - b_setup); end
  endtask

  task automatic test_frame_timeout();
    mark();
    send_frame(72'h57_4000, 3);
    repeat (FRAME_TIMEOUT - 200) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ftmo_busy_before: got %b, required 1", busy); end
    repeat (300) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ftmo_busy_after: got %b, required 0", busy); end
    rdata = 32'hA5A55A5A;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
    send_frame(72'h52_40000000, 5);
    wait_done("ftmo_rd");
    total++; if (setups - b_setup !== 1) begin bad++; $display("FAIL ftmo_setups: got %0d, required 1", setups - b_setup); end
    total++; if (cap_addr !== 32'h40000000) begin bad++; $display("FAIL ftmo_paddr: got %08h, required 40000000", cap_addr); end
    total++; if (cap_write !== 1'b0) begin bad++; $display("FAIL ftmo_pwrite: got %b, required 0", cap_write); end
  endtask

  // The low pulse is kept shorter than half a bit time at the bench divider.
  task automatic test_glitch();
    mark();
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CLK_DIV / 2 - 6) @(negedge clk);
    uart_rx = 1'b1;
    repeat (12 * CLK_DIV) @(negedge clk);
    total++; if (tx_bytes - b_tx !== 0) begin bad++; $display("FAIL glitch_tx_count: got %0d, required 0", tx_bytes - b_tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy: got %b, required 0", busy); end
  endtask

  task automatic test_async_reset();
    int n;
    waits = -1;
    send_frame(72'h52_40000014, 5);
    n = 0;
    while (m_penable !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++; if (n >= 200) begin bad++; $display("FAIL arst_access: got penable=%b, required 1", m_penable); end
    repeat (5) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    total++; if (m_psel !== 1'b0) begin bad++; $display("FAIL arst_psel: got %b, required 0", m_psel); end
    total++; if (m_penable !== 1'b0) begin bad++; $display("FAIL arst_penable: got %b, required 0", m_penable); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b, required 0", busy); end
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL arst_tx: got %b, required 1", uart_tx); end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    waits = 0;
    repeat (4) @(negedge clk);
    mark();
    exp_q.push_back(8'h4B);
    send_frame(72'h57_40000020_01020304, 9);
    wait_done("arst_wr");
    total++; if (cap_addr !== 32'h40000020) begin bad++; $display("FAIL arst_paddr: got %08h, required 40000020", cap_addr); end
    total++; if (cap_wdata !== 32'h01020304) begin bad++; $display("FAIL arst_pwdata: got %08h, required 01020304", cap_wdata); end
    total++; if (cap_write !== 1'b1) begin bad++; $display("FAIL arst_pwrite: got %b, required 1", cap_write); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_bad_cmd();
    test_framing();
    test_frame_timeout();
    test_glitch();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
